maze_path_player: RTL
=====================

Name: maze_path_player

Overview:
- Read side of the rat-in-maze path stack.
- During the search, the solver pushes one 2-bit direction per forward move and pops one entry on each backtrack.
- After `run` is asserted, this block replays the stored path from the start cell, oldest entry first.
- Each move is emitted on a valid/ready handshake, and the block tracks the rat's current (row, col) as moves are accepted.

Parameters:
- DEPTH, 256, maximum number of stored moves (power of two).
- PTR_W, 8, log2(DEPTH).
- COORD_W, 4, row/col width; the maze is 2^COORD_W x 2^COORD_W.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  solver pushes wr_dir onto the path stack.
- wr_dir  in  2  direction to push: 0=up (row-1), 1=right (col+1), 2=left (col-1), 3=down (row+1).
- pop  in  1  solver backtrack; removes the top entry.
- run  in  1  level; starts replay when sampled high in IDLE.
- mv_ready  in  1  downstream accepts the current move.
- mv_valid  out  1  mv_dir is valid.
- mv_dir  out  2  direction being replayed.
- row  out  COORD_W  rat row after the last accepted move.
- col  out  COORD_W  rat column after the last accepted move.
- depth  out  PTR_W+1  number of stored entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- busy  out  1  FSM is in PLAY.
- play_done  out  1  one-cycle pulse when the last move is accepted, or on an empty run.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to IDLE; top=0; rd_ptr=0; row=0; col=0.
  - mv_valid=0, mv_dir=0, busy=0, play_done=0.
  - Stack contents are don't-care.
  - Reset mid-PLAY aborts replay and empties the stack.
- Stack update in IDLE only:
  - push and !full: mem[top] <= wr_dir, top <= top+1.
  - pop and !empty: top <= top-1.
  - push and pop in the same cycle with !empty: overwrite mem[top-1] with wr_dir; top is unchanged (replace-top).
  - push and pop in the same cycle with empty: treated as a push.
  - push when full is dropped; pop when empty is ignored. No error flag.
- FSM states:
  - IDLE:
    - run=1 and depth>0: go to PLAY; rd_ptr<=0; row,col<=0.
    - run=1 and depth==0: play_done pulses the next cycle; stay in IDLE.
  - PLAY:
    - push and pop are ignored; busy=1.
    - mv_valid=1 and mv_dir=mem[rd_ptr], registered so they are stable the cycle after entry.
    - First mv_valid occurs exactly 1 cycle after run is sampled (registered read).
    - On a handshake (mv_valid and mv_ready):
      - row/col update per mv_dir, modulo 2^COORD_W (wrap: 0-1 -> 15, 15+1 -> 0).
      - rd_ptr increments.
      - If rd_ptr was top-1: go to DONE; mv_valid deasserts the next cycle; play_done pulses for 1 cycle in that same next cycle.
      - Otherwise the next entry is presented in the cycle after the handshake. Back-to-back moves at 1/cycle are supported with mv_ready held high.
    - mv_ready low holds mv_valid and mv_dir stable (no drop, no change).
    - run deasserting during PLAY has no effect.
  - DONE:
    - row/col hold the final position; stack contents are retained.
    - Return to IDLE when run=0.
    - A new run from IDLE replays the same path again.
- Combinational flags: depth=top; full and empty are derived from top.

Test Plan:
- Pushes then replay: push 1,1,3,3,2 with run=0, then run=1 and mv_ready=1 -> mv_dir sequence 1,1,3,3,2 on 5 consecutive cycles starting 1 cycle after run; final row=2, col=1; play_done pulses once; depth=5 throughout.
- Backtrack editing: push 1, push 3, pop, push 1, then same-cycle push 0 + pop -> depth=2 and stack=[1,0]; replay gives 1,0; final row=15 (wrap), col=1.
- Backpressure: 3 stored moves; mv_ready toggles 1,0,0,1,1 -> each mv_dir is held while ready=0; exactly 3 handshakes; row/col update only on handshake cycles.
- Full/empty bounds: 256 pushes -> full=1 and depth=256; a 257th push is dropped; 257 pops -> empty=1 and depth=0; run with empty -> play_done pulse, mv_valid never asserts, busy stays 0.
- Push/pop during PLAY: push/pop during replay -> depth unchanged and replay unaffected.
- Reset mid-replay and repeat run: rst after 2 of 5 moves -> busy=0, mv_valid=0, depth=0, row=col=0 the next cycle; a separate run after DONE (run dropped then re-raised) replays the identical sequence.

Source files
------------

// File: rtl/maze_path_player.sv
// Path stack for the rat-in-maze solver with in-order replay.
// Moves are streamed on a valid/ready handshake while (row, col) is tracked.
module maze_path_player #(
    parameter int DEPTH   = 256,
    parameter int PTR_W   = 8,
    parameter int COORD_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [1:0]         wr_dir,
    input  logic               pop,
    input  logic               run,
    input  logic               mv_ready,
    output logic               mv_valid,
    output logic [1:0]         mv_dir,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic [PTR_W:0]     depth,
    output logic               full,
    output logic               empty,
    output logic               busy,
    output logic               play_done
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [PTR_W:0]     top_q, top_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COORD_W-1:0] row_q, row_d;
    logic [COORD_W-1:0] col_q, col_d;
    logic               mv_valid_q, mv_valid_d;
    logic [1:0]         mv_dir_q, mv_dir_d;
    logic               done_q, done_d;

    logic               wr_en;
    logic [PTR_W-1:0]   wr_addr;
    logic [PTR_W:0]     tm1;
    logic [PTR_W-1:0]   rd_nxt;
    logic               is_full, is_empty, hs, last;

    always_comb begin
        is_full    = (top_q == FULL_CNT);
        is_empty   = (top_q == '0);
        tm1        = top_q - 1'b1;
        rd_nxt     = rd_ptr_q + 1'b1;
        hs         = mv_valid_q & mv_ready;
        last       = ({1'b0, rd_ptr_q} == tm1);
        state_d    = state_q;
        top_d      = top_q;
        rd_ptr_d   = rd_ptr_q;
        row_d      = row_q;
        col_d      = col_q;
        mv_valid_d = mv_valid_q;
        mv_dir_d   = mv_dir_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = top_q[PTR_W-1:0];
        unique case (state_q)
            IDLE: begin
                // Simultaneous push+pop on a non-empty stack rewrites the top.
                if (push && pop && !is_empty) begin
                    wr_en   = 1'b1;
                    wr_addr = tm1[PTR_W-1:0];
                end else if (push && !is_full) begin
                    wr_en = 1'b1;
                    top_d = top_q + 1'b1;
                end else if (pop && !is_empty) begin
                    top_d = tm1;
                end
                if (run) begin
                    if (!is_empty) begin
                        state_d    = PLAY;
                        rd_ptr_d   = '0;
                        row_d      = '0;
                        col_d      = '0;
                        mv_valid_d = 1'b1;
                        mv_dir_d   = mem[0];
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (hs) begin
                    unique case (mv_dir_q)
                        2'd0: row_d = row_q - 1'b1;
                        2'd1: col_d = col_q + 1'b1;
                        2'd2: col_d = col_q - 1'b1;
                        2'd3: row_d = row_q + 1'b1;
                    endcase
                    if (last) begin
                        state_d    = DONE;
                        mv_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rd_ptr_d = rd_nxt;
                        mv_dir_d = mem[rd_nxt];
                    end
                end
            end
            DONE: begin
                if (!run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            top_q      <= '0;
            rd_ptr_q   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mv_valid_q <= 1'b0;
            mv_dir_q   <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            top_q      <= top_d;
            rd_ptr_q   <= rd_ptr_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mv_valid_q <= mv_valid_d;
            mv_dir_q   <= mv_dir_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dir;
        end
    end

    assign mv_valid  = mv_valid_q;
    assign mv_dir    = mv_dir_q;
    assign row       = row_q;
    assign col       = col_q;
    assign depth     = top_q;
    assign full      = is_full;
    assign empty     = is_empty;
    assign busy      = (state_q == PLAY);
    assign play_done = done_q;

endmodule
